// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered Rijndael ShiftRows / InvShiftRows stage with a
// 2-entry output FIFO. The permutation is pure wiring selected per block by
// in_inv; only the permuted block and its tag are buffered.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int W = 32*NB;

  // Row offsets; 256-bit blocks use the wider 0,1,3,4 schedule.
  function automatic int row_shift(input int r);
    case (r)
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      3:       return (NB == 8) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Byte k = 4*c + r sits at bits [W-1-8k -: 8]; each output byte is a
  // 2:1 mux between its forward and inverse source bytes.
  logic [W-1:0] perm;
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S  = row_shift(r);
      localparam int CF = (c + S) % NB;
      localparam int CI = (c - S + NB) % NB;
      assign perm[W-1-8*(4*c+r) -: 8] = in_inv ? in_data[W-1-8*(4*CI+r) -: 8]
                                               : in_data[W-1-8*(4*CF+r) -: 8];
    end
  end

  logic [1:0][W-1:0]     data_q;
  logic [1:0][TAG_W-1:0] tag_q;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_ptr, push, pop;

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready  = (cnt_q != 2'd2) && !rst;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign wr_ptr = rd_ptr_q ^ cnt_q[0];

  // Occupancy and head pointer next state.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // FIFO state; reset drops everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        data_q[wr_ptr] <= perm;
        tag_q[wr_ptr]  <= in_tag;
      end
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances on one clock.
module tb_shift_rows_pipe;
  logic         clk, rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_tag, out_tag;
  logic         in8_valid, in8_ready, in8_inv, out8_valid, out8_ready;
  logic [255:0] in8_data, out8_data;
  logic [3:0]   in8_tag, out8_tag;
  logic [255:0] cap8;
  int total = 0;
  int bad   = 0;

  localparam logic [127:0] A    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AINV = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] AFWD = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [255:0] B8   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag));

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_inv(in8_inv), .in_data(in8_data), .in_tag(in8_tag),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data),
    .out_tag(out8_tag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive4(input logic v, input logic inv, input logic [127:0] d, input logic [3:0] t);
    in_valid = v; in_inv = inv; in_data = d; in_tag = t;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; drive4(1'b0, 1'b0, '0, '0);
    in8_valid = 1'b0; in8_inv = 1'b0; in8_data = '0; in8_tag = '0; out8_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // NB=4 inverse, forward, then round trip of the forward result
    drive4(1'b1, 1'b1, A, 4'd1);
    tick();
    chk("inv_valid", out_valid, 1);
    chk("inv_data", out_data, AINV);
    chk("inv_tag", out_tag, 1);
    drive4(1'b1, 1'b0, A, 4'd2);
    tick();
    chk("fwd_data", out_data, AFWD);
    chk("fwd_tag", out_tag, 2);
    drive4(1'b1, 1'b1, AFWD, 4'd3);
    tick();
    chk("rt_data", out_data, A);
    chk("rt_tag", out_tag, 3);
    drive4(1'b0, 1'b0, '0, '0);
    tick();
    chk("drain_valid", out_valid, 0);

    // NB=8 forward, then inverse round trip
    in8_valid = 1'b1; in8_inv = 1'b0; in8_data = B8; in8_tag = 4'd5;
    tick();
    chk("nb8_valid", out8_valid, 1);
    chk("nb8_col0", out8_data[255:224], 32'h00050e13);
    chk("nb8_col7", out8_data[31:0], 32'h1c010a0f);
    chk("nb8_tag", out8_tag, 5);
    cap8 = out8_data;
    in8_inv = 1'b1; in8_data = cap8; in8_tag = 4'd6;
    tick();
    chk("nb8_rt", out8_data, B8);
    chk("nb8_rt_tag", out8_tag, 6);
    in8_valid = 1'b0;
    tick();
    chk("nb8_drain", out8_valid, 0);

    // Backpressure: three blocks offered, two held, third waits at source
    out_ready = 1'b0;
    drive4(1'b1, 1'b1, A, 4'd4);
    tick();
    chk("bp_rdy1", in_ready, 1);
    drive4(1'b1, 1'b0, A, 4'd5);
    tick();
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_head_data", out_data, AINV);
    drive4(1'b1, 1'b1, AFWD, 4'd6);
    tick();
    chk("bp_stall_rdy", in_ready, 0);
    chk("bp_stall_data", out_data, AINV);
    chk("bp_stall_tag", out_tag, 4);
    tick();
    chk("bp_stall2_data", out_data, AINV);
    chk("bp_stall2_tag", out_tag, 4);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_data", out_data, AFWD);
    chk("bp_pop1_tag", out_tag, 5);
    chk("bp_pop1_rdy", in_ready, 1);
    tick();
    chk("bp_pop2_data", out_data, A);
    chk("bp_pop2_tag", out_tag, 6);
    drive4(1'b0, 1'b0, '0, '0);
    tick();
    chk("bp_empty", out_valid, 0);

    // Reset while full
    out_ready = 1'b0;
    drive4(1'b1, 1'b1, A, 4'd7);
    tick();
    drive4(1'b1, 1'b0, A, 4'd8);
    tick();
    drive4(1'b0, 1'b0, '0, '0);
    chk("mr_full_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mr_valid_drop", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_rel_ready", in_ready, 1);
    chk("mr_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    drive4(1'b1, 1'b1, A, 4'd9);
    tick();
    chk("mr_next_data", out_data, AINV);
    chk("mr_next_tag", out_tag, 9);
    drive4(1'b0, 1'b0, '0, '0);
    tick();
    chk("mr_final_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Registered, handshaked Rijndael ShiftRows/InvShiftRows stage, parametrised over block width. Each transaction selects forward or inverse permutation. A 2-entry output buffer lets the block run at one block per cycle under backpressure. It replaces the fixed 128-bit combinational inverse permutation in the decryptor datapath. The same block also serves encrypt-side and 192/256-bit-block variants.

## Interface
- `NB`, default 4: state columns (Nb); legal values 4, 6, 8; any other value is an elaboration error.
- `TAG_W`, default 4: width of the sideband tag carried alongside each block (≥1).
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset; asynchronous and active-high.
- `in_valid`  input  1  input block valid.
- `in_ready`  output  1  block can accept input.
- `in_inv`  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with the block.
- `in_data`  input  32*NB  state, column-major, MSB-first.
- `in_tag`  input  TAG_W  sideband, passed through unmodified.
- `out_valid`  output  1  output block valid.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  32*NB  permuted state.
- `out_tag`  output  TAG_W  tag of the block on `out_data`.

## Operation
- Byte k (k = 0 .. 4*NB-1) occupies bits [32*NB-1-8k -: 8]. Row r = k mod 4, column c = k div 4.
- Row shift s(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Inverse: out[r][c] = in[r][(c − s(r)) mod NB].
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Row 0 always passes through unchanged.
- The permutation is computed combinationally from `in_data`/`in_inv` and written into the buffer on accept. Only permuted data is stored; the mode bit is not stored.
- Buffer: 2-entry FIFO (entries + read pointer + 2-bit count, values 0..2).
  - Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
  - `in_ready` = (count != 2), derived from registered count only; no combinational path from `out_ready`.
  - `out_valid` = (count != 0); `out_data`/`out_tag` = head entry.
- Count update:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle (count = 1): count unchanged; the new block becomes the head in the next cycle.
- Full (count = 2): `in_ready` = 0; `in_valid` is ignored and no data is corrupted.
- Empty (count = 0): `out_valid` = 0; `out_data` holds its last value (don't care).
- Order is strictly FIFO; tags stay bound to their blocks.
- `in_inv` may change every transaction; mixed-mode streams are legal.

## Timing
- Reset (asynchronous assert, synchronous release):
  - count = 0, pointers = 0, `out_valid` = 0, entries cleared to 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Latency: a block accepted at edge N is presented with `out_valid` = 1 after edge N, so it can be consumed at edge N+1.
- Throughput: 1 block/cycle sustained with `out_ready` held high.
- Stall recovery: with count = 2, a pop at edge N makes `in_ready` = 1 after edge N (one bubble on input).
- Reset mid-stream: all buffered blocks are dropped, `out_valid` falls immediately (asynchronous), and no partial block is emitted afterwards.
- `out_valid`/`out_data` must stay stable while `out_valid && !out_ready`.

## Test plan
- NB=4, inv=1, `in_data` = 000102030405060708090a0b0c0d0e0f -> `out_data` = 000d0a07_04010e0b_0805020f_0c090603 one cycle later.
- NB=4, inv=0, same input -> 00050a0f_04090e03_080d0207_0c01060b.
- NB=4, round trip: forward result fed back with inv=1 -> original value; tags 1 and 2 emerge in order.
- NB=8, inv=0, bytes 00..1f -> row 3 of column 0 = byte 0x13 (column 4), row 2 of column 0 = byte 0x0e (column 3); round trip restores the input.
- Backpressure: `out_ready` = 0, push 3 blocks -> 2 accepted, `in_ready` = 0, and the third is held by the source. Raise `out_ready` -> all 3 blocks emerge in order, and no output changes while stalled.
- Reset with count = 2 -> `out_valid` = 0 immediately; after release `in_ready` = 1 and the next block emerges at latency 1.
